pe_pass_scheduler: RTL

// - Sequences one PE through a full convolution pass: accepts a pass descriptor, configures the PE and pulses its enable.
// - Tracks filter/ifmap/ipsum/opsum beats, opening one phase at a time to the upstream GLB/router via per-stream req lines.
// - Sits between the PE-array top-level controller and a single PE; one instance per PE (or per PE row sharing a config).

---
 rtl/pe_pass_scheduler.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/pe_pass_scheduler.sv
// pe_pass_scheduler: sequences a single PE through one convolution pass.
// Accepts a pass descriptor, configures the PE, pulses its enable, then opens
// the filter/ifmap/ipsum/opsum phases one at a time while counting beats.
// Optional feature macro: PASS_WDOG_EN adds an idle-beat watchdog that aborts
// a stalled pass after WDOG_CYCLES cycles without a counted fire.
module pe_pass_scheduler #(
    parameter int unsigned CONFIG_SIZE = 13,
    parameter int unsigned WDOG_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   job_valid,
    output logic                   job_ready,
    input  logic [CONFIG_SIZE-1:0] job_cfg,
    output logic                   pe_en,
    output logic [CONFIG_SIZE-1:0] pe_config,
    input  logic                   filter_fire,
    input  logic                   ifmap_fire,
    input  logic                   ipsum_fire,
    input  logic                   opsum_fire,
    output logic                   filter_req,
    output logic                   ifmap_req,
    output logic                   ipsum_req,
    output logic [4:0]             col_idx,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    typedef enum logic [2:0] {
        StIdle,
        StCfg,
        StFilter,
        StIfmap,
        StIpsum,
        StOpsum,
        StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [CONFIG_SIZE-1:0] cfg_q, cfg_d;
    logic [4:0]             cnt_q, cnt_d;
    logic [4:0]             col_q, col_d;
    logic                   err_q, err_d;

    // Decoded pass geometry (all counts are field value + 1)
    logic [2:0] rs_n, p_n, q_n;
    logic [4:0] f_last;
    logic       dw;
    logic [4:0] n_flt, n_ps, n_if;

    assign rs_n   = {1'b0, cfg_q[11:10]} + 3'd1;
    assign p_n    = {1'b0, cfg_q[8:7]} + 3'd1;
    assign q_n    = {1'b0, cfg_q[1:0]} + 3'd1;
    assign f_last = cfg_q[6:2];
    assign dw     = cfg_q[12];
    assign n_flt  = {2'b00, p_n} * {2'b00, rs_n};
    assign n_ps   = dw ? {2'b00, q_n} : {2'b00, p_n};
    // First column loads a full rs-wide window; later columns slide by one word
    assign n_if   = (col_q == 5'd0) ? {2'b00, rs_n} : 5'd1;

    logic       phase_fire;
    logic [4:0] phase_target;
    logic       in_phase;
    logic       stray;

    // Select the fire line and beat target belonging to the open phase
    always_comb begin
        phase_fire   = 1'b0;
        phase_target = 5'd0;
        in_phase     = 1'b0;
        unique case (state_q)
            StFilter: begin
                phase_fire   = filter_fire;
                phase_target = n_flt;
                in_phase     = 1'b1;
            end
            StIfmap: begin
                phase_fire   = ifmap_fire;
                phase_target = n_if;
                in_phase     = 1'b1;
            end
            StIpsum: begin
                phase_fire   = ipsum_fire;
                phase_target = n_ps;
                in_phase     = 1'b1;
            end
            StOpsum: begin
                phase_fire   = opsum_fire;
                phase_target = n_ps;
                in_phase     = 1'b1;
            end
            default: ;
        endcase
    end

    // Any fire on a stream whose phase is not open is a protocol error
    assign stray = (filter_fire && (state_q != StFilter)) ||
                   (ifmap_fire  && (state_q != StIfmap))  ||
                   (ipsum_fire  && (state_q != StIpsum))  ||
                   (opsum_fire  && (state_q != StOpsum));

`ifdef PASS_WDOG_EN
    logic [15:0] wdog_q, wdog_d;
    logic        wdog_trip;

    assign wdog_trip = in_phase && !phase_fire && (wdog_q == 16'(WDOG_CYCLES - 1));
`endif

    // Next-state: phase sequencing, beat counting and error capture
    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (job_valid) begin
                    cfg_d   = job_cfg;
                    err_d   = 1'b0;
                    cnt_d   = 5'd0;
                    col_d   = 5'd0;
                    state_d = StCfg;
                end
            end
            StCfg: begin
                cnt_d   = 5'd0;
                state_d = StFilter;
            end
            StFilter, StIfmap, StIpsum, StOpsum: begin
                if (phase_fire) begin
                    if (cnt_q + 5'd1 == phase_target) begin
                        cnt_d = 5'd0;
                        case (state_q)
                            StFilter: state_d = StIfmap;
                            StIfmap:  state_d = StIpsum;
                            StIpsum:  state_d = StOpsum;
                            default: begin
                                if (col_q == f_last) begin
                                    state_d = StDone;
                                end else begin
                                    col_d   = col_q + 5'd1;
                                    state_d = StIfmap;
                                end
                            end
                        endcase
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (stray) begin
            err_d = 1'b1;
        end
`ifdef PASS_WDOG_EN
        if (wdog_trip) begin
            err_d   = 1'b1;
            state_d = StIdle;
        end
`endif
    end

`ifdef PASS_WDOG_EN
    // Idle counter restarts on every counted beat and every phase change
    always_comb begin
        wdog_d = 16'd0;
        if (in_phase && !phase_fire && (state_d == state_q)) begin
            wdog_d = wdog_q + 16'd1;
        end
    end

    // Watchdog register
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q <= 16'd0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cfg_q   <= '0;
            cnt_q   <= 5'd0;
            col_q   <= 5'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            err_q   <= err_d;
        end
    end

    assign job_ready  = (state_q == StIdle);
    assign pe_en      = (state_q == StCfg);
    assign pe_config  = cfg_q;
    assign filter_req = (state_q == StFilter);
    assign ifmap_req  = (state_q == StIfmap);
    assign ipsum_req  = (state_q == StIpsum);
    assign col_idx    = col_q;
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);
    assign err        = err_q;

endmodule
